decode_stage: RTL
=================

# decode_stage

Registered instruction-decode stage between instruction fetch and execute. It accepts 32-bit RV32I instructions over a valid/ready handshake and splits them into register fields and control fields. It assembles the raw immediate bits and the one-hot width select that the immediate extender consumes downstream. A two-entry skid buffer gives the fetch side a registered ready; a flush input discards in-flight instructions.

## Interface
Parameters:
- XLEN, 32, datapath and PC width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of the instruction.
- if_ready  out  1  stage can accept an instruction this cycle.
- flush  in  1  discard all held instructions (branch redirect).
- id_valid  out  1  decoded instruction available.
- id_ready  in  1  execute accepts the decoded instruction.
- id_pc  out  32  PC of the decoded instruction.
- id_opcode  out  7  instr[6:0].
- id_rd, id_rs1, id_rs2  out  5 each  instr[11:7], [19:15], [24:20].
- id_funct3  out  3  instr[14:12].
- id_funct7  out  7  instr[31:25].
- id_imm_raw  out  32  assembled immediate bits, zero above the field width.
- id_imm_sel  out  3  one-hot extender select: 001 = 12-bit, 010 = 13-bit, 100 = 21-bit, 000 = none.
- id_imm_ext_en  out  1  extender sign-extends id_imm_raw; when 0 it passes id_imm_raw through.
- id_illegal  out  1  unsupported encoding.

## Operation
Decode is done combinationally on if_instr before the instruction is registered. Immediate handling depends on the opcode:
- I-type (0010011, 0000011, 1100111, 1110011, 0001111): imm_raw[11:0] = instr[31:20]; sel = 001; ext_en = 1.
- S-type (0100011): imm_raw[11:0] = {instr[31:25], instr[11:7]}; sel = 001; ext_en = 1.
- B-type (1100011): imm_raw[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; sel = 010; ext_en = 1.
- J-type (1101111): imm_raw[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 0}; sel = 100; ext_en = 1.
- U-type (0110111, 0010111): imm_raw = {instr[31:12], 12'h000}; sel = 000; ext_en = 0.
- R-type (0110011): imm_raw = 0; sel = 000; ext_en = 0.
- Any other opcode, or instr[1:0] != 2'b11: illegal = 1, imm_raw = 0, sel = 000, ext_en = 0.
- Register and funct fields are always copied verbatim, including for illegal instructions.

Storage is a main output register (M) plus a skid register (S), each holding a valid bit and the full decoded payload.
- if_ready = !S.valid && !flush && !rst.
- A transfer out occurs when id_valid && id_ready. A transfer in occurs when if_valid && if_ready.
- Transfer in with M empty, or M draining this cycle and S empty: the decoded instruction loads M.
- Transfer in with M full and not draining: the instruction loads S.
- M drains while S is full: S moves to M and S is cleared.
- Order is strictly preserved. No instruction is lost or duplicated.
- The id_* payload is stable whenever id_valid = 1 and id_ready = 0.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on id_* with id_valid = 1 after edge N.
- Full throughput is one instruction per cycle while id_ready = 1.
- Reset, and the cycle after it: M.valid = S.valid = 0, id_valid = 0, and all id_* payload = 0. if_ready = 0 while rst = 1 and 1 in the first cycle after rst falls.
- Flush in cycle N: if_ready = 0 in cycle N, so no instruction is accepted. After edge N, M.valid = S.valid = 0. id_valid may be 1 during cycle N; a handshake completing in cycle N counts as delivered.
- Flush and rst asserted together: rst dominates, with an identical result.
- Skid full (S.valid = 1): if_ready = 0 until the cycle after M drains.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093) -> next cycle: id_valid = 1, rd = 1, rs1 = 2, imm_raw = 0x00000FFF, sel = 001, ext_en = 1, illegal = 0.
- BEQ x0,x0,-4 (0xFE000EE3) -> imm_raw = 0x00001FFC, sel = 010, ext_en = 1. JAL x1,+2048 (0x001000EF) -> imm_raw = 0x00000800, sel = 100.
- LUI x5,0x12345 (0x123452B7) -> imm_raw = 0x12345000, sel = 000, ext_en = 0, rd = 5. Word 0x00000000 -> illegal = 1.
- Backpressure: hold id_ready = 0 and offer A, B, C back-to-back. A sits in M, B in S, and if_ready = 0 from the cycle after B is accepted, so C stalls. Then set id_ready = 1: A, B, C emerge in order on consecutive cycles with no gaps or duplicates.
- Flush with M and S both full, if_valid = 1 -> id_valid = 0 next cycle, the presented instruction is not accepted, and if_ready = 1 the following cycle.
- Assert rst mid-stream with M and S full -> id_valid = 0 and payload = 0 after the edge. if_ready stays 0 while rst is high, and normal accept resumes the cycle after release.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered RV32I instruction-decode stage between fetch and execute.
//   Instructions are decoded combinationally on entry and then held in a
//   two-entry skid buffer: a main output register (M) and a skid register (S).
//   The skid register lets if_ready come straight from a flop, so the fetch
//   side never sees a combinational path from id_ready.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   if_valid/ready  fetch-side handshake; if_instr, if_pc are the payload
//   flush           discard every held instruction (branch redirect)
//   id_valid/ready  execute-side handshake
//   id_pc           PC of the decoded instruction
//   id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_funct7
//                   raw instruction fields, copied verbatim
//   id_imm_raw      assembled immediate bits, zero above the field width
//   id_imm_sel      one-hot extender width: 001=12b, 010=13b, 100=21b, 000=none
//   id_imm_ext_en   1 = extender sign-extends id_imm_raw, 0 = pass-through
//   id_illegal      unsupported encoding
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [31:0]     id_imm_raw,
  output logic [2:0]      id_imm_sel,
  output logic            id_imm_ext_en,
  output logic            id_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm_raw;
    logic [2:0]      imm_sel;
    logic            imm_ext_en;
    logic            illegal;
  } payload_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_12   = 3'b001;
  localparam logic [2:0] SEL_13   = 3'b010;
  localparam logic [2:0] SEL_21   = 3'b100;

  payload_t dec;
  payload_t m_data, s_data;
  logic     m_valid, s_valid;
  logic     xfer_in, xfer_out;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // value unassigned; otherwise synthesis infers latches.
    dec            = '0;
    dec.pc         = if_pc;
    dec.opcode     = if_instr[6:0];
    dec.rd         = if_instr[11:7];
    dec.funct3     = if_instr[14:12];
    dec.rs1        = if_instr[19:15];
    dec.rs2        = if_instr[24:20];
    dec.funct7     = if_instr[31:25];
    dec.imm_raw    = '0;
    dec.imm_sel    = SEL_NONE;
    dec.imm_ext_en = 1'b0;
    dec.illegal    = 1'b0;

    if (if_instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      unique case (if_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
          dec.imm_raw[11:0] = if_instr[31:20];
          dec.imm_sel       = SEL_12;
          dec.imm_ext_en    = 1'b1;
        end
        7'b0100011: begin
          dec.imm_raw[11:0] = {if_instr[31:25], if_instr[11:7]};
          dec.imm_sel       = SEL_12;
          dec.imm_ext_en    = 1'b1;
        end
        7'b1100011: begin
          dec.imm_raw[12:0] = {if_instr[31], if_instr[7], if_instr[30:25],
                               if_instr[11:8], 1'b0};
          dec.imm_sel       = SEL_13;
          dec.imm_ext_en    = 1'b1;
        end
        7'b1101111: begin
          dec.imm_raw[20:0] = {if_instr[31], if_instr[19:12], if_instr[20],
                               if_instr[30:21], 1'b0};
          dec.imm_sel       = SEL_21;
          dec.imm_ext_en    = 1'b1;
        end
        7'b0110111, 7'b0010111: begin
          dec.imm_raw = {if_instr[31:12], 12'h000};
        end
        7'b0110011: begin
          // R-type: no immediate, defaults already describe it.
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------------
  // if_ready depends only on flop state plus flush/rst, never on id_ready.
  assign if_ready = !s_valid && !flush && !rst;
  assign xfer_in  = if_valid && if_ready;
  assign xfer_out = m_valid && id_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the payload registers are reset too, because id_* must read
      // zero after reset rather than stale data.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      // A handshake in the flush cycle already delivered M; everything else
      // is discarded. Payload is left as is since id_valid masks it.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || xfer_out) begin
      // M is free or draining: refill from S first to preserve order.
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (xfer_in) begin
        m_data  <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (xfer_in) begin
      // M is stalled: park the new instruction in S (if_ready drops next).
      s_data  <= dec;
      s_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign id_valid      = m_valid;
  assign id_pc         = m_data.pc;
  assign id_opcode     = m_data.opcode;
  assign id_rd         = m_data.rd;
  assign id_rs1        = m_data.rs1;
  assign id_rs2        = m_data.rs2;
  assign id_funct3     = m_data.funct3;
  assign id_funct7     = m_data.funct7;
  assign id_imm_raw    = m_data.imm_raw;
  assign id_imm_sel    = m_data.imm_sel;
  assign id_imm_ext_en = m_data.imm_ext_en;
  assign id_illegal    = m_data.illegal;

endmodule
